dual_store_buffer: RTL and testbench
====================================

Name: dual_store_buffer

Overview:
- Store buffer between the two lane EX/MEM stages and the dual-port data memory.
- Buffers stores from both lanes in program order and drains them into the memory's two write ports, up to two per cycle.
- Lets loads from either lane forward data from buffered stores that the memory has not yet received.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- DW, 32, data width.
- AW, 32, address width; only address[7:0] is significant for matching, because memory indexing uses address[7:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st_valid_1  in  1  lane-1 store request.
- st_addr_1  in  AW  lane-1 store address.
- st_data_1  in  DW  lane-1 store data.
- st_valid_2  in  1  lane-2 store request; lane 2 is younger than lane 1 in the same cycle.
- st_addr_2  in  AW  lane-2 store address.
- st_data_2  in  DW  lane-2 store data.
- st_ready  out  1  buffer can accept two stores this cycle.
- ld_addr_1  in  AW  lane-1 load lookup address.
- fwd_hit_1  out  1  a buffered store matches ld_addr_1.
- fwd_data_1  out  DW  data of the youngest matching entry for ld_addr_1.
- ld_addr_2  in  AW  lane-2 load lookup address.
- fwd_hit_2  out  1  a buffered store matches ld_addr_2.
- fwd_data_2  out  DW  data of the youngest matching entry for ld_addr_2.
- drain_en  in  1  memory write ports are available this cycle.
- mem_memwrite_1  out  1  write strobe to memory port 1.
- mem_address_1  out  AW  address for memory port 1.
- mem_write_data_1  out  DW  data for memory port 1.
- mem_memwrite_2  out  1  write strobe to memory port 2.
- mem_address_2  out  AW  address for memory port 2.
- mem_write_data_2  out  DW  data for memory port 2.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- overflow  out  1  sticky error flag.

Behaviour:
Storage and reset
- Circular FIFO with head and tail pointers; pointers wrap modulo DEPTH.
- rst_n low asynchronously clears head, tail, count and all entry valids.
- rst_n low also clears overflow and forces mem_memwrite_1/2, fwd_hit_1/2 and st_ready... to their empty-buffer values: mem_memwrite_1/2=0, fwd_hit_1/2=0, st_ready=1.
- Reset during an in-flight drain discards all contents; no write strobe is issued in the reset cycle.

Enqueue
- st_ready = (DEPTH - count) >= 2, computed from registered count only.
- There is no same-cycle dequeue credit: st_ready ignores entries draining in the current cycle.
- On a rising edge with st_ready=1:
  - valid_1 only: writes entry[tail], tail+1.
  - valid_2 only: writes entry[tail], tail+1.
  - Both valid: lane 1 goes to entry[tail], lane 2 to entry[tail+1], tail+2.
- Any st_valid while st_ready=0 is dropped and sets overflow; overflow clears only on reset.

Drain
- Drain path is combinational from the registered head entries.
- mem_memwrite_1 = drain_en & valid[head]; port 1 carries entry[head].
- mem_memwrite_2 = drain_en & valid[head+1] & (addr[head][7:0] != addr[head+1][7:0]); port 2 carries entry[head+1].
- When the two head entries share an address, only port 1 drains that cycle, which preserves write order.
- On the clock edge, head advances by the number of strobes asserted and those entries are invalidated.
- count_next = count + enq - deq, evaluated in the same cycle. Simultaneous enqueue and dequeue is legal.

Forwarding
- Combinational lookup over all valid entries, including entries draining this cycle.
- Match condition: addr[7:0] equality.
- The youngest match (closest to tail) supplies fwd_data.
- No match: fwd_hit=0, fwd_data=0.
- Stores presented in the current cycle are not visible to lookup until the next cycle.

Test Plan:
1. Reset, then st_valid_1=1, addr=0x10, data=0xAA, drain_en=0 -> next cycle count=1, ld_addr_1=0x10 gives fwd_hit_1=1, fwd_data_1=0xAA; mem_memwrite_1=0.
2. Both lanes store 0x20/0x11 and 0x20/0x22 in one cycle, drain_en=0 -> forward returns 0x22 (youngest). Raise drain_en -> cycle 1: only port 1 writes 0x11; cycle 2: port 1 writes 0x22; count goes 2→1→0.
3. Two stores to 0x30 and 0x31, drain_en=1 -> both ports strobe in the same cycle; count 2→0.
4. DEPTH=4: fill to count=3 with drain_en=0 -> st_ready=0. Assert st_valid_1 -> store dropped, overflow=1, count stays 3, head/tail wrap verified.
5. Continuous two-store enqueue with drain_en=1 for 10 cycles, addresses 0x00..0x13 -> memory model receives all 20 writes in program order, count stays at or below 2, overflow=0.
6. With count=3, pull rst_n low mid-cycle -> count=0, mem_memwrite_1/2=0 and fwd_hit_1/2=0 immediately, overflow=0; after release, a fresh store is accepted at entry 0.

Source files
------------

// File: rtl/dual_store_buffer.sv
// Dual-lane store buffer: in-order FIFO of stores from both lanes, two-port drain
// into data memory, and youngest-match load forwarding over all buffered entries.
module dual_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid_1,
    input  logic [AW-1:0]            st_addr_1,
    input  logic [DW-1:0]            st_data_1,
    input  logic                     st_valid_2,
    input  logic [AW-1:0]            st_addr_2,
    input  logic [DW-1:0]            st_data_2,
    output logic                     st_ready,
    input  logic [AW-1:0]            ld_addr_1,
    output logic                     fwd_hit_1,
    output logic [DW-1:0]            fwd_data_1,
    input  logic [AW-1:0]            ld_addr_2,
    output logic                     fwd_hit_2,
    output logic [DW-1:0]            fwd_data_2,
    input  logic                     drain_en,
    output logic                     mem_memwrite_1,
    output logic [AW-1:0]            mem_address_1,
    output logic [DW-1:0]            mem_write_data_1,
    output logic                     mem_memwrite_2,
    output logic [AW-1:0]            mem_address_2,
    output logic [DW-1:0]            mem_write_data_2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;
    localparam int unsigned MW    = 8;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W-1:0] wr2_ptr;
    logic [PTR_W-1:0] scan_idx;
    logic             enq_1;
    logic             enq_2;
    logic [1:0]       n_enq;
    logic [1:0]       n_deq;
    logic [CW-1:0]    count_nxt;
    logic             unused_ld_bits;

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);

    // Readiness looks only at the registered count; draining entries give no credit.
    assign st_ready = (count <= READY_MAX);
    assign enq_1    = st_ready & st_valid_1;
    assign enq_2    = st_ready & st_valid_2;
    assign wr2_ptr  = st_valid_1 ? tail_p1 : tail;
    assign n_enq    = {1'b0, enq_1} + {1'b0, enq_2};

    // Port 2 holds off when both head entries hit the same memory word.
    assign mem_memwrite_1   = drain_en & ent_valid[head];
    assign mem_address_1    = ent_addr[head];
    assign mem_write_data_1 = ent_data[head];
    assign mem_memwrite_2   = drain_en & ent_valid[head_p1]
                              & (ent_addr[head][MW-1:0] != ent_addr[head_p1][MW-1:0]);
    assign mem_address_2    = ent_addr[head_p1];
    assign mem_write_data_2 = ent_data[head_p1];
    assign n_deq            = {1'b0, mem_memwrite_1} + {1'b0, mem_memwrite_2};

    assign count_nxt = count + CW'(n_enq) - CW'(n_deq);

    assign unused_ld_bits = ^{ld_addr_1[AW-1:MW], ld_addr_2[AW-1:MW]};

    // Entry valid bits after this cycle's drain and enqueue.
    always_comb begin
        valid_nxt = ent_valid;
        if (mem_memwrite_1) valid_nxt[head]    = 1'b0;
        if (mem_memwrite_2) valid_nxt[head_p1] = 1'b0;
        if (enq_1)          valid_nxt[tail]    = 1'b1;
        if (enq_2)          valid_nxt[wr2_ptr] = 1'b1;
    end

    // Scan oldest to youngest so the last match (nearest tail) wins.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2  = 1'b0;
        fwd_data_2 = '0;
        scan_idx   = head;
        for (int i = 0; i < int'(DEPTH); i++) begin
            scan_idx = head + PTR_W'(i);
            if (ent_valid[scan_idx] && ent_addr[scan_idx][MW-1:0] == ld_addr_1[MW-1:0]) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = ent_data[scan_idx];
            end
            if (ent_valid[scan_idx] && ent_addr[scan_idx][MW-1:0] == ld_addr_2[MW-1:0]) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = ent_data[scan_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            overflow  <= 1'b0;
        end else begin
            head      <= head + PTR_W'(n_deq);
            tail      <= tail + PTR_W'(n_enq);
            count     <= count_nxt;
            ent_valid <= valid_nxt;
            if ((st_valid_1 | st_valid_2) & ~st_ready) overflow <= 1'b1;
        end
    end

    // Payload storage needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (enq_1) begin
            ent_addr[tail] <= st_addr_1;
            ent_data[tail] <= st_data_1;
        end
        if (enq_2) begin
            ent_addr[wr2_ptr] <= st_addr_2;
            ent_data[wr2_ptr] <= st_data_2;
        end
    end

endmodule

// File: tb/tb_dual_store_buffer.sv
// Bench for dual_store_buffer: directed vector table, reset/ordering sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_dual_store_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid_1, st_valid_2, st_ready;
    logic [AW-1:0] st_addr_1, st_addr_2, ld_addr_1, ld_addr_2;
    logic [DW-1:0] st_data_1, st_data_2, fwd_data_1, fwd_data_2;
    logic          fwd_hit_1, fwd_hit_2, drain_en;
    logic          mem_memwrite_1, mem_memwrite_2;
    logic [AW-1:0] mem_address_1, mem_address_2;
    logic [DW-1:0] mem_write_data_1, mem_write_data_2;
    logic [2:0]    count;
    logic          overflow;

    dual_store_buffer #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid_1(st_valid_1), .st_addr_1(st_addr_1), .st_data_1(st_data_1),
        .st_valid_2(st_valid_2), .st_addr_2(st_addr_2), .st_data_2(st_data_2),
        .st_ready(st_ready),
        .ld_addr_1(ld_addr_1), .fwd_hit_1(fwd_hit_1), .fwd_data_1(fwd_data_1),
        .ld_addr_2(ld_addr_2), .fwd_hit_2(fwd_hit_2), .fwd_data_2(fwd_data_2),
        .drain_en(drain_en),
        .mem_memwrite_1(mem_memwrite_1), .mem_address_1(mem_address_1),
        .mem_write_data_1(mem_write_data_1),
        .mem_memwrite_2(mem_memwrite_2), .mem_address_2(mem_address_2),
        .mem_write_data_2(mem_write_data_2),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Directed vector: inputs for one cycle and outputs expected before its clock edge.
    typedef struct {
        logic        v1; logic [31:0] a1; logic [31:0] d1;
        logic        v2; logic [31:0] a2; logic [31:0] d2;
        logic [31:0] la1; logic [31:0] la2; logic drain;
        logic [2:0]  e_count; logic e_ready;
        logic        e_hit1; logic [31:0] e_fd1;
        logic        e_hit2; logic [31:0] e_fd2;
        logic        e_mw1; logic [31:0] e_wd1;
        logic        e_mw2; logic [31:0] e_wd2;
        logic        e_ovf;
    } vec_t;
    vec_t vecs[$];

    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
    ent_t mq[$];
    ent_t mem_log[$];
    ent_t exp_log[$];
    logic m_ovf;

    task automatic drive(input logic v1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic v2, input logic [31:0] a2, input logic [31:0] d2,
                         input logic [31:0] la1, input logic [31:0] la2, input logic dr);
        st_valid_1 = v1; st_addr_1 = a1; st_data_1 = d1;
        st_valid_2 = v2; st_addr_2 = a2; st_data_2 = d2;
        ld_addr_1 = la1; ld_addr_2 = la2; drain_en = dr;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 32'h10, 32'h20, 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", 64'(count), 64'd0);
        chk("rst st_ready", 64'(st_ready), 64'd1);
        chk("rst mw1", 64'(mem_memwrite_1), 64'd0);
        chk("rst mw2", 64'(mem_memwrite_2), 64'd0);
        chk("rst hit1", 64'(fwd_hit_1), 64'd0);
        chk("rst hit2", 64'(fwd_hit_2), 64'd0);
        chk("rst overflow", 64'(overflow), 64'd0);
        rst_n = 1'b1;
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] la, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].addr[7:0] == la[7:0]) begin
                hit = 1'b1;
                d   = mq[i].data;
                break;
            end
        end
    endtask

    // One cycle against the reference model: compare mid-cycle, then retire/enqueue at the edge.
    task automatic model_cycle(input string tag);
        logic e_ready, e_mw1, e_mw2, h1, h2;
        logic [31:0] f1, f2;
        int n;
        ent_t e;
        @(negedge clk);
        n       = mq.size();
        e_ready = (int'(DEPTH) - n) >= 2;
        e_mw1   = drain_en && n >= 1;
        e_mw2   = drain_en && n >= 2 && (mq[0].addr[7:0] != mq[1].addr[7:0]);
        lookup(ld_addr_1, h1, f1);
        lookup(ld_addr_2, h2, f2);
        chk({tag, " count"}, 64'(count), 64'(n));
        chk({tag, " st_ready"}, 64'(st_ready), 64'(e_ready));
        chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, " hit1"}, 64'(fwd_hit_1), 64'(h1));
        chk({tag, " fwd1"}, 64'(fwd_data_1), 64'(f1));
        chk({tag, " hit2"}, 64'(fwd_hit_2), 64'(h2));
        chk({tag, " fwd2"}, 64'(fwd_data_2), 64'(f2));
        chk({tag, " mw1"}, 64'(mem_memwrite_1), 64'(e_mw1));
        chk({tag, " mw2"}, 64'(mem_memwrite_2), 64'(e_mw2));
        if (e_mw1) begin
            chk({tag, " addr1"}, 64'(mem_address_1), 64'(mq[0].addr));
            chk({tag, " wdata1"}, 64'(mem_write_data_1), 64'(mq[0].data));
        end
        if (e_mw2) begin
            chk({tag, " addr2"}, 64'(mem_address_2), 64'(mq[1].addr));
            chk({tag, " wdata2"}, 64'(mem_write_data_2), 64'(mq[1].data));
        end
        if (mem_memwrite_1) begin e.addr = mem_address_1; e.data = mem_write_data_1; mem_log.push_back(e); end
        if (mem_memwrite_2) begin e.addr = mem_address_2; e.data = mem_write_data_2; mem_log.push_back(e); end
        @(posedge clk);
        if (e_mw1) void'(mq.pop_front());
        if (e_mw2) void'(mq.pop_front());
        if (e_ready) begin
            if (st_valid_1) begin e.addr = st_addr_1; e.data = st_data_1; mq.push_back(e); end
            if (st_valid_2) begin e.addr = st_addr_2; e.data = st_data_2; mq.push_back(e); end
        end else if (st_valid_1 || st_valid_2) begin
            m_ovf = 1'b1;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // v1 a1 d1, v2 a2 d2, la1 la2 drain | count ready hit1 fd1 hit2 fd2 mw1 wd1 mw2 wd2 ovf
        vecs.push_back('{1,'h10,'hAA, 0,0,0, 'h10,'h10,0, 0,1, 0,0, 0,0, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h10,'h11,0, 1,1, 1,'hAA, 0,0, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h10,'h11,1, 1,1, 1,'hAA, 0,0, 1,'hAA, 0,0, 0});
        vecs.push_back('{1,'h20,'h11, 1,'h20,'h22, 'h20,'h20,0, 0,1, 0,0, 0,0, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h20,'h20,0, 2,1, 1,'h22, 1,'h22, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h20,'h21,1, 2,1, 1,'h22, 0,0, 1,'h11, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h20,'h21,1, 1,1, 1,'h22, 0,0, 1,'h22, 0,0, 0});
        vecs.push_back('{1,'h30,'h33, 1,'h31,'h44, 'h30,'h31,1, 0,1, 0,0, 0,0, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h30,'h31,1, 2,1, 1,'h33, 1,'h44, 1,'h33, 1,'h44, 0});
        vecs.push_back('{1,'h40,'h01, 1,'h41,'h02, 'h40,'h41,0, 0,1, 0,0, 0,0, 0,0, 0,0, 0});
        vecs.push_back('{1,'h42,'h03, 0,0,0, 'h40,'h41,0, 2,1, 1,'h01, 1,'h02, 0,0, 0,0, 0});
        vecs.push_back('{1,'h43,'h04, 0,0,0, 'h43,'h42,0, 3,0, 0,0, 1,'h03, 0,0, 0,0, 0});
        vecs.push_back('{0,0,0, 0,0,0, 'h43,'h42,0, 3,0, 0,0, 1,'h03, 0,0, 0,0, 1});
        vecs.push_back('{0,0,0, 0,0,0, 'h41,'h40,1, 3,0, 1,'h02, 1,'h01, 1,'h01, 1,'h02, 1});
        vecs.push_back('{1,'h44,'h05, 1,'h45,'h06, 'h42,'h44,1, 1,1, 1,'h03, 0,0, 1,'h03, 0,0, 1});
        vecs.push_back('{0,0,0, 0,0,0, 'h44,'h45,1, 2,1, 1,'h05, 1,'h06, 1,'h05, 1,'h06, 1});
        vecs.push_back('{0,0,0, 1,'h50,'h07, 'h44,'h45,0, 0,1, 0,0, 0,0, 0,0, 0,0, 1});
        vecs.push_back('{0,0,0, 0,0,0, 'h50,'h51,0, 1,1, 1,'h07, 0,0, 0,0, 0,0, 1});
        vecs.push_back('{0,0,0, 0,0,0, 'h50,'h51,1, 1,1, 1,'h07, 0,0, 1,'h07, 0,0, 1});
        vecs.push_back('{0,0,0, 0,0,0, 'h50,'h51,0, 0,1, 0,0, 0,0, 0,0, 0,0, 1});

        do_reset();

        // Directed table: forwarding, same-address drain ordering, full/overflow, pointer wrap.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].v1, vecs[i].a1, vecs[i].d1, vecs[i].v2, vecs[i].a2, vecs[i].d2,
                  vecs[i].la1, vecs[i].la2, vecs[i].drain);
            @(negedge clk);
            chk($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].e_count));
            chk($sformatf("vec%0d st_ready", i), 64'(st_ready), 64'(vecs[i].e_ready));
            chk($sformatf("vec%0d hit1", i), 64'(fwd_hit_1), 64'(vecs[i].e_hit1));
            chk($sformatf("vec%0d fwd1", i), 64'(fwd_data_1), 64'(vecs[i].e_fd1));
            chk($sformatf("vec%0d hit2", i), 64'(fwd_hit_2), 64'(vecs[i].e_hit2));
            chk($sformatf("vec%0d fwd2", i), 64'(fwd_data_2), 64'(vecs[i].e_fd2));
            chk($sformatf("vec%0d mw1", i), 64'(mem_memwrite_1), 64'(vecs[i].e_mw1));
            chk($sformatf("vec%0d mw2", i), 64'(mem_memwrite_2), 64'(vecs[i].e_mw2));
            if (vecs[i].e_mw1) chk($sformatf("vec%0d wdata1", i), 64'(mem_write_data_1), 64'(vecs[i].e_wd1));
            if (vecs[i].e_mw2) chk($sformatf("vec%0d wdata2", i), 64'(mem_write_data_2), 64'(vecs[i].e_wd2));
            chk($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].e_ovf));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle with three entries and an active drain.
        drive(1, 'h60, 'h61, 1, 'h61, 'h62, 'h60, 'h62, 0);
        @(posedge clk); #1;
        drive(1, 'h62, 'h63, 0, 0, 0, 'h60, 'h62, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 'h60, 'h62, 1);
        #1;
        chk("mid count pre", 64'(count), 64'd3);
        chk("mid mw1 pre", 64'(mem_memwrite_1), 64'd1);
        chk("mid hit2 pre", 64'(fwd_hit_2), 64'd1);
        chk("mid ovf pre", 64'(overflow), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid count", 64'(count), 64'd0);
        chk("mid mw1", 64'(mem_memwrite_1), 64'd0);
        chk("mid mw2", 64'(mem_memwrite_2), 64'd0);
        chk("mid hit1", 64'(fwd_hit_1), 64'd0);
        chk("mid hit2", 64'(fwd_hit_2), 64'd0);
        chk("mid overflow", 64'(overflow), 64'd0);
        chk("mid st_ready", 64'(st_ready), 64'd1);
        @(posedge clk); #1;
        chk("mid mw1 edge", 64'(mem_memwrite_1), 64'd0);
        rst_n = 1'b1;
        drive(1, 'h55, 'h77, 0, 0, 0, 'h55, 'h60, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 'h55, 'h60, 1);
        #1;
        chk("post count", 64'(count), 64'd1);
        chk("post hit1", 64'(fwd_hit_1), 64'd1);
        chk("post fwd1", 64'(fwd_data_1), 64'h77);
        chk("post hit2", 64'(fwd_hit_2), 64'd0);
        chk("post mw1", 64'(mem_memwrite_1), 64'd1);
        chk("post addr1", 64'(mem_address_1), 64'h55);
        @(posedge clk); #1;
        chk("post drained", 64'(count), 64'd0);

        // Sustained two-store stream with drain: all writes reach memory in program order.
        do_reset();
        mem_log.delete();
        exp_log.delete();
        for (int k = 0; k < 10; k++) begin
            ent_t e1, e2;
            e1.addr = 32'(2 * k);     e1.data = $urandom;
            e2.addr = 32'(2 * k + 1); e2.data = $urandom;
            exp_log.push_back(e1);
            exp_log.push_back(e2);
            drive(1, e1.addr, e1.data, 1, e2.addr, e2.data, e1.addr, e2.addr, 1);
            model_cycle($sformatf("stream%0d", k));
            chk($sformatf("stream%0d count<=2", k), 64'(count <= 3'd2), 64'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) model_cycle($sformatf("flush%0d", k));
        chk("stream writes", 64'(mem_log.size()), 64'd20);
        for (int i = 0; i < exp_log.size() && i < mem_log.size(); i++) begin
            chk($sformatf("stream order addr%0d", i), 64'(mem_log[i].addr), 64'(exp_log[i].addr));
            chk($sformatf("stream order data%0d", i), 64'(mem_log[i].data), 64'(exp_log[i].data));
        end
        chk("stream overflow", 64'(overflow), 64'd0);

        // Randomized traffic; upper address bits vary to show only [7:0] matters.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a1, a2, l1, l2;
            a1 = $urandom; a1[7:0] = 8'($urandom_range(0, 5));
            a2 = $urandom; a2[7:0] = 8'($urandom_range(0, 5));
            l1 = $urandom; l1[7:0] = 8'($urandom_range(0, 5));
            l2 = $urandom; l2[7:0] = 8'($urandom_range(0, 5));
            drive(1'($urandom_range(0, 99) < 55), a1, $urandom,
                  1'($urandom_range(0, 99) < 45), a2, $urandom,
                  l1, l2, 1'($urandom_range(0, 99) < 55));
            model_cycle($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
